// File: rtl/matrix_alu_if.sv
// ---------------------------------------------------------------------------
// matrix_alu_if
//   Handshake and operand/result bus between the top-level controller and
//   the matrix ALU. Matrices are 4x4 elements of ELEM_W bits, flattened so
//   element (r,c) sits at bits [ELEM_W*(4r+c) +: ELEM_W].
//
//   Signals:
//     start   controller -> ALU  operation request (looked at only when idle)
//     opcode  controller -> ALU  00 add, 01 sub, 10 multiply, 11 transpose(A)
//     mat_a   controller -> ALU  operand A
//     mat_b   controller -> ALU  operand B (unused by transpose)
//     busy    ALU -> controller  high from the accepting edge until done drops
//     done    ALU -> controller  one-cycle pulse when result is updated
//     result  ALU -> controller  last completed result
//
//   Modports: master (controller side), slave (ALU side).
// ---------------------------------------------------------------------------
interface matrix_alu_if #(
    parameter int ELEM_W = 16
);
    logic                   start;
    logic [1:0]             opcode;
    logic [16*ELEM_W-1:0]   mat_a;
    logic [16*ELEM_W-1:0]   mat_b;
    logic                   busy;
    logic                   done;
    logic [16*ELEM_W-1:0]   result;

    modport master (
        output start,
        output opcode,
        output mat_a,
        output mat_b,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  opcode,
        input  mat_a,
        input  mat_b,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/matrix_alu.sv
// ---------------------------------------------------------------------------
// matrix_alu
//   Compute stage behind the matrix register file. Accepts two 4x4 matrices
//   of ELEM_W-bit unsigned elements, performs add / sub / multiply /
//   transpose(A) one element per clock, and publishes the whole 16-element
//   result at once so the write-back path never sees partial data.
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset (clears state, operands, result)
//     alu_if  matrix_alu_if.slave: start/opcode/mat_a/mat_b in,
//             busy/done/result out
//
//   Timing: start accepted at edge E (only while idle), elements 0..15 are
//   produced on edges E+1..E+16, done is high for the cycle after E+16 and
//   the next request can be taken at edge E+18.
//
//   Build option:
//     SATURATE_EN  undefined (default): arithmetic wraps modulo 2^ELEM_W,
//                  multiply keeps the low ELEM_W bits of the full sum.
//                  defined: add/mult clamp to all-ones on overflow, sub
//                  clamps to zero when A<B; transpose and timing unchanged.
// ---------------------------------------------------------------------------
module matrix_alu #(
    parameter int ELEM_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    matrix_alu_if.slave alu_if
);

    localparam int BUS_W = 16 * ELEM_W;
    localparam int MAC_W = 2 * ELEM_W + 2;   // four full products summed

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [1:0]          op_q;
    logic [3:0]          idx_q;
    logic [ELEM_W-1:0]   a_q       [16];
    logic [ELEM_W-1:0]   b_q       [16];
    // Elements 0..14 wait here; element 15 goes straight into the result.
    logic [ELEM_W-1:0]   scratch_q [15];
    logic [BUS_W-1:0]    result_q;

    logic                accept;
    logic                last_elem;
    logic [1:0]          row;
    logic [1:0]          col;
    logic [MAC_W-1:0]    mac_sum;
    logic [ELEM_W-1:0]   elem_val;

    // -----------------------------------------------------------------------
    // Result reduction. Inputs carry one carry/borrow bit (add/sub) or the
    // full-width dot product (mult); the function brings them to ELEM_W.
    // -----------------------------------------------------------------------
`ifdef SATURATE_EN
    function automatic logic [ELEM_W-1:0] fit_add(input logic [ELEM_W:0] s);
        return s[ELEM_W] ? {ELEM_W{1'b1}} : s[ELEM_W-1:0];
    endfunction

    // Bit ELEM_W of a zero-extended difference is the borrow (A<B).
    function automatic logic [ELEM_W-1:0] fit_sub(input logic [ELEM_W:0] s);
        return s[ELEM_W] ? {ELEM_W{1'b0}} : s[ELEM_W-1:0];
    endfunction

    function automatic logic [ELEM_W-1:0] fit_mul(input logic [MAC_W-1:0] s);
        return (|s[MAC_W-1:ELEM_W]) ? {ELEM_W{1'b1}} : s[ELEM_W-1:0];
    endfunction
`else
    function automatic logic [ELEM_W-1:0] fit_add(input logic [ELEM_W:0] s);
        return s[ELEM_W-1:0];
    endfunction

    function automatic logic [ELEM_W-1:0] fit_sub(input logic [ELEM_W:0] s);
        return s[ELEM_W-1:0];
    endfunction

    function automatic logic [ELEM_W-1:0] fit_mul(input logic [MAC_W-1:0] s);
        return s[ELEM_W-1:0];
    endfunction
`endif

    // Full-width unsigned product of two elements.
    function automatic logic [2*ELEM_W-1:0] mul_full(input logic [ELEM_W-1:0] x,
                                                     input logic [ELEM_W-1:0] y);
        return {{ELEM_W{1'b0}}, x} * {{ELEM_W{1'b0}}, y};
    endfunction

    assign accept    = (state_q == S_IDLE) && alu_if.start;
    assign last_elem = (idx_q == 4'd15);
    assign row       = idx_q[3:2];
    assign col       = idx_q[1:0];

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (alu_if.start) state_d = S_CALC;
            S_CALC:  if (last_elem)    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. busy covers CALC and DONE, so it drops together with done.
    // -----------------------------------------------------------------------
    always_comb begin
        alu_if.busy   = (state_q != S_IDLE);
        alu_if.done   = (state_q == S_DONE);
        alu_if.result = result_q;
    end

    // -----------------------------------------------------------------------
    // Element datapath: value of element idx=4*row+col for the latched op.
    // The multiply sums all four full-width products in a single cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        mac_sum = '0;
        for (int k = 0; k < 4; k++) begin
            mac_sum = mac_sum + {2'b00, mul_full(a_q[{row, k[1:0]}], b_q[{k[1:0], col}])};
        end

        unique case (op_q)
            2'b00:   elem_val = fit_add({1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]});
            2'b01:   elem_val = fit_sub({1'b0, a_q[idx_q]} - {1'b0, b_q[idx_q]});
            2'b10:   elem_val = fit_mul(mac_sum);
            default: elem_val = a_q[{col, row}];
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand capture, element sequencing and result publication.
    // Operands are copied on the accepting edge, so the bus may change
    // freely while the operation runs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            idx_q    <= 4'd0;
            result_q <= '0;
            for (int i = 0; i < 16; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i < 15; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (accept) begin
            op_q  <= alu_if.opcode;
            idx_q <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                a_q[i] <= alu_if.mat_a[ELEM_W*i +: ELEM_W];
                b_q[i] <= alu_if.mat_b[ELEM_W*i +: ELEM_W];
            end
        end else if (state_q == S_CALC) begin
            idx_q <= idx_q + 4'd1;
            if (!last_elem) begin
                scratch_q[idx_q] <= elem_val;
            end else begin
                // All 16 elements land together: the result never shows a
                // mix of old and new data.
                for (int i = 0; i < 15; i++) begin
                    result_q[ELEM_W*i +: ELEM_W] <= scratch_q[i];
                end
                result_q[ELEM_W*15 +: ELEM_W] <= elem_val;
            end
        end
    end

endmodule

// File: tb/tb_matrix_alu.sv
// ---------------------------------------------------------------------------
// tb_matrix_alu
//   Directed bench for matrix_alu. A behavioural model computes each result
//   from plain matrix arithmetic and tracks the expected busy/done window as
//   a countdown from the accepting edge; a compare process checks busy,
//   done and result against it on every falling edge. Hand-computed
//   literals pin both the model and the DUT for each directed case.
// ---------------------------------------------------------------------------
module tb_matrix_alu;

    localparam int EW = 16;
    localparam int BW = 16 * EW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    matrix_alu_if #(.ELEM_W(EW)) bus ();

    matrix_alu #(.ELEM_W(EW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_if (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- checking helpers ----------------
    task automatic chk_v(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- matrix helpers ----------------
    function automatic logic [EW-1:0] el(input logic [BW-1:0] m, input int r, input int c);
        return m[EW*(4*r+c) +: EW];
    endfunction

    function automatic logic [BW-1:0] fill(input logic [EW-1:0] v);
        logic [BW-1:0] m;
        for (int i = 0; i < 16; i++) m[EW*i +: EW] = v;
        return m;
    endfunction

    // Reference: ordinary matrix arithmetic in 64-bit integers, then reduced.
    function automatic logic [BW-1:0] model_op(input logic [1:0] op,
                                                input logic [BW-1:0] a,
                                                input logic [BW-1:0] b);
        logic [BW-1:0] res;
        longint        v;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = 0;
                case (op)
                    2'b00: v = longint'(el(a, r, c)) + longint'(el(b, r, c));
                    2'b01: v = longint'(el(a, r, c)) - longint'(el(b, r, c));
                    2'b10: for (int k = 0; k < 4; k++) v += longint'(el(a, r, k)) * longint'(el(b, k, c));
                    default: v = longint'(el(a, c, r));
                endcase
`ifdef SATURATE_EN
                if (v > 65535) v = 65535;
                else if (v < 0) v = 0;
`endif
                res[EW*(4*r+c) +: EW] = v[EW-1:0];
            end
        end
        return res;
    endfunction

    // ---------------- cycle model ----------------
    // m_left: cycles of busy remaining; 17 after the accepting edge, the
    // done cycle is the one where it reads 1.
    int            m_left   = 0;
    logic [BW-1:0] m_pending = '0;
    logic [BW-1:0] m_result  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_result <= '0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left    <= 17;
                m_pending <= model_op(bus.opcode, bus.mat_a, bus.mat_b);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_result <= m_pending;
        end
    end

    always @(negedge clk) begin
        chk_i("cyc_busy", int'(bus.busy), int'(m_left > 0));
        chk_i("cyc_done", int'(bus.done), int'(m_left == 1));
        chk_v("cyc_result", bus.result, m_result);
    end

    // ---------------- stimulus helpers ----------------
    // Request one op; start is dropped and operands scrambled one cycle later
    // so the DUT must work from its own copies.
    task automatic issue(input logic [1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.mat_a  = a;
        bus.mat_b  = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.opcode = ~op;
        bus.mat_a  = ~a;
        bus.mat_b  = ~b;
    endtask

    // Counts falling edges (first one already elapsed) until done, bounded.
    task automatic wait_done(input string name, output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, want 17", name, cyc);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input logic [BW-1:0] exp);
        int lat;
        issue(op, a, b);
        wait_done(name, lat);
        chk_i({name, "_latency"}, lat, 17);
        chk_v(name, bus.result, exp);
        @(negedge clk);
        chk_i({name, "_busy_off"}, int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [BW-1:0] ident, seq, tpa, tpx, rnd;
    logic [EW-1:0] add_exp, sub_exp;
    int            lat, gap, dones;

    initial begin
        bus.start  = 1'b0;
        bus.opcode = 2'b00;
        bus.mat_a  = '0;
        bus.mat_b  = '0;

`ifdef SATURATE_EN
        add_exp = 16'hFFFF;
        sub_exp = 16'h0000;
`else
        add_exp = 16'h0001;
        sub_exp = 16'hFFFE;
`endif
        ident = '0;
        for (int i = 0; i < 16; i++) begin
            seq[EW*i +: EW] = EW'(i);
            rnd[EW*i +: EW] = EW'($urandom);
        end
        for (int r = 0; r < 4; r++) begin
            ident[EW*(5*r) +: EW] = 16'h0001;
            for (int c = 0; c < 4; c++) begin
                tpa[EW*(4*r+c) +: EW] = EW'(16 * r + c);
                tpx[EW*(4*r+c) +: EW] = EW'(16 * c + r);
            end
        end

        // Model pinned against hand-computed values.
        chk_v("model_add", model_op(2'b00, fill(16'hFFFF), fill(16'h0002)), fill(add_exp));
        chk_v("model_sub", model_op(2'b01, fill(16'h0003), fill(16'h0005)), fill(sub_exp));
        chk_v("model_mul", model_op(2'b10, fill(16'h0002), fill(16'h0003)), fill(16'h0018));
        chk_v("model_tp",  model_op(2'b11, tpa, rnd), tpx);

        // Reset state.
        repeat (3) @(negedge clk);
        chk_i("rst_busy", int'(bus.busy), 0);
        chk_i("rst_done", int'(bus.done), 0);
        chk_v("rst_result", bus.result, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("add_wrap",  2'b00, fill(16'hFFFF), fill(16'h0002), fill(add_exp));
        run_op("sub_under", 2'b01, fill(16'h0003), fill(16'h0005), fill(sub_exp));
        run_op("mul_ident", 2'b10, ident, seq, seq);
        run_op("mul_const", 2'b10, fill(16'h0002), fill(16'h0003), fill(16'h0018));
        run_op("transpose", 2'b11, tpa, rnd, tpx);

        // Reset mid-CALC: outputs clear immediately, nothing completes later.
        issue(2'b00, fill(16'h1111), fill(16'h2222));
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_i("midrst_busy", int'(bus.busy), 0);
        chk_i("midrst_done", int'(bus.done), 0);
        chk_v("midrst_result", bus.result, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk_i("midrst_no_done", dones, 0);

        // Held start: first op accepted, the changed request during CALC is
        // ignored, then picked up at E+18 with the old result held meanwhile.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = 2'b00;
        bus.mat_a  = fill(16'h1234);
        bus.mat_b  = fill(16'h0101);
        @(negedge clk);
        bus.opcode = 2'b01;
        bus.mat_a  = fill(16'h1000);
        bus.mat_b  = fill(16'h0001);
        wait_done("hold_first", lat);
        chk_i("hold_first_latency", lat, 17);
        chk_v("hold_first", bus.result, fill(16'h1335));
        gap = 0;
        @(negedge clk);
        gap++;
        while (!bus.done && gap < 40) begin
            if (gap == 17) chk_v("hold_old_kept", bus.result, fill(16'h1335));
            @(negedge clk);
            gap++;
        end
        bus.start = 1'b0;
        chk_i("hold_gap", gap, 18);
        chk_v("hold_second", bus.result, fill(16'h0FFF));
        repeat (3) @(negedge clk);
        chk_i("final_idle", int'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_alu.md
Name: matrix_alu

Overview:
- Compute stage directly downstream of the matrix register file.
- Consumes two 4x4x16-bit matrices read from the register file, performs add, subtract, multiply or transpose element-serially, and presents a 256-bit result for write-back into the register file.
- A start/busy/done handshake lets the top-level controller sequence register reads, the operation, and the write-back.

Parameters:
- ELEM_W, 16, element width in bits. Matrix is fixed at 4x4, so the bus width is 16*ELEM_W (256 at default).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only in IDLE
- opcode  input  2  00 add, 01 sub, 10 multiply, 11 transpose(A)
- mat_a  input  16*ELEM_W  operand A
- mat_b  input  16*ELEM_W  operand B; ignored for transpose
- busy  output  1  high from the accepting edge until done deasserts
- done  output  1  one-cycle pulse when result is updated
- result  output  16*ELEM_W  last completed result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Element layout: element (r,c), r,c in 0..3, occupies bits [ELEM_W*(4r+c) +: ELEM_W]. Row 0 col 0 is the LSBs.
- Reset (rst_n=0, any time including mid-operation):
  - state=IDLE, busy=0, done=0, result=0.
  - Internal operand, index and accumulator registers cleared.
  - Operation in flight is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at a rising edge latches mat_a, mat_b and opcode into internal copies.
  - idx<=0, busy<=1, state<=CALC.
  - Inputs may change after the accepting edge without effect.
- CALC: each edge computes element idx=4r+c into a scratch result, then idx<=idx+1.
  - add: A[r][c]+B[r][c]
  - sub: A[r][c]-B[r][c]
  - mult: sum over k=0..3 of A[r][k]*B[k][c]. The full sum is computed in one cycle, with products and sum kept at full width before reduction.
  - transpose: A[c][r]
  - After the edge that writes idx=15: result<=scratch (all 16 elements at once), done<=1, state<=DONE.
- DONE: done=1 for exactly this cycle. Next edge: done<=0, busy<=0, state<=IDLE.
- Latency: accepting edge E, then done is high in the cycle after edge E+16 and result is valid from that same cycle. A new start is accepted no earlier than edge E+18.
- result holds its value until the next completion. It never shows partial data.
- start while busy (CALC or DONE): ignored, not queued.
- start held high continuously: back-to-back operations, one accepted per IDLE visit.
- Arithmetic, default build (SATURATE_EN undefined):
  - Unsigned, modulo 2^ELEM_W.
  - Overflow and underflow wrap.
  - Multiply keeps the low ELEM_W bits of the full sum.

Optional Feature:
- Macro SATURATE_EN.
- Defined: unsigned saturating arithmetic.
  - add and mult clamp to all-ones ({ELEM_W{1'b1}}) when the true value exceeds 2^ELEM_W-1.
  - sub clamps to 0 when A<B.
  - transpose unaffected.
  - Timing and handshake identical.
- Undefined: modulo wrap as above. No saturation logic is synthesized.

Test Plan:
- Reset mid-CALC: start add, assert rst_n=0 after 5 cycles -> busy=0, done=0, result=256'h0 immediately (asynchronously); no done pulse ever follows.
- Add wrap: A all elements 16'hFFFF, B all 16'h0002, opcode 00 -> done in cycle after edge E+16, every element 16'h0001 (SATURATE_EN: 16'hFFFF).
- Sub underflow: A all 16'h0003, B all 16'h0005, opcode 01 -> every element 16'hFFFE (SATURATE_EN: 16'h0000).
- Multiply:
  - A=identity, B element (r,c)=4r+c, opcode 10 -> result equals B.
  - A all 16'h0002, B all 16'h0003 -> every element 16'h0018.
- Transpose: A element (r,c)=16'h0010*r+c, opcode 11, B=random -> result element (r,c)=16'h0010*c+r; B has no effect.
- Handshake: pulse start during CALC with different opcode -> ignored, first result unchanged.
  - Hold start high -> second operation accepted at edge E+18.
  - result stays at the old value until the second done.
